// File: rtl/cfa_diag_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : cfa_diag_window_gen
// Description : Producer for the R/B diagonal-interpolation stage. Accepts a
//               raster stream of (interpolated G, raw R/B) pairs and emits,
//               per centre pixel, the four diagonal G taps and the four
//               diagonal R/B taps. Two line buffers hold {G,RB}; borders are
//               mirrored (-1 -> 1, N -> N-2) to keep the Bayer phase. The last
//               row is flushed from the line buffer with in_ready held low.
//               Optional macro CFA_WIN_COORD_EN adds out_row/out_col.
// Revision    : 1.0 - initial release
// ============================================================================
module cfa_diag_window_gen #(
  parameter int DataBitWidth = 12,
  parameter int ImgWidth     = 640,
  parameter int ImgHeight    = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DataBitWidth-1:0] G_in,
  input  logic [DataBitWidth-1:0] RB_in,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic [DataBitWidth-1:0] G_m1_m1,
  output logic [DataBitWidth-1:0] G_m1_p1,
  output logic [DataBitWidth-1:0] G_p1_m1,
  output logic [DataBitWidth-1:0] G_p1_p1,
  output logic [DataBitWidth-1:0] RB_m1_m1,
  output logic [DataBitWidth-1:0] RB_m1_p1,
  output logic [DataBitWidth-1:0] RB_p1_m1,
  output logic [DataBitWidth-1:0] RB_p1_p1
`ifdef CFA_WIN_COORD_EN
  ,
  output logic [$clog2(ImgHeight)-1:0] out_row,
  output logic [$clog2(ImgWidth)-1:0]  out_col
`endif
);

  localparam int c_dw2 = 2 * DataBitWidth;
  localparam int c_cw  = $clog2(ImgWidth);
  localparam int c_rw  = $clog2(ImgHeight);
  localparam logic [c_cw-1:0] c_col_last = c_cw'(ImgWidth - 1);
  localparam logic [c_cw-1:0] c_col_one  = c_cw'(1);
  localparam logic [c_rw-1:0] c_row_last = c_rw'(ImgHeight - 1);
  localparam logic [c_rw-1:0] c_row_one  = c_rw'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Line buffers: r_line1 holds the previous row, r_line2 the row before it.
  logic [c_dw2-1:0] r_line1 [ImgWidth];
  logic [c_dw2-1:0] r_line2 [ImgWidth];

  logic [c_cw-1:0]  r_col;
  logic [c_rw-1:0]  r_row;
  logic             r_ready;
  logic             r_eol_pend;
  logic             r_fl_done;
  // Horizontal delays: current row at col-1/col-2, row-2 at col-1/col-2.
  logic [c_dw2-1:0] r_cur_d1, r_cur_d2, r_up_d1, r_up_d2;
  // End-of-line window taps are captured in dedicated registers so the
  // following accept (column 0, which never produces a window) is never stalled.
  logic [c_dw2-1:0] r_eol_up, r_eol_dn;

  logic             w_accept, w_col_last, w_row_last, w_win, w_fl_step;
  logic [c_dw2-1:0] w_pix, w_old1, w_old2;
  logic [c_dw2-1:0] w_dn_l, w_up_l, w_up_r, w_fl_l, w_fl_r;
  logic [c_cw-1:0]  w_fl_li, w_fl_ri;
  logic             w_ov, w_osof, w_oeol;
  logic [c_dw2-1:0] w_ul, w_ur, w_dl, w_dr;

`ifdef CFA_WIN_COORD_EN
  logic [c_rw-1:0]  r_eol_row;
  logic [c_rw-1:0]  w_orow;
  logic [c_cw-1:0]  w_ocol;
`endif

  assign in_ready = r_ready;

  // Tap selection for the accept path, with row/column mirroring at borders.
  always_comb begin
    w_accept   = in_valid & r_ready;
    w_pix      = {G_in, RB_in};
    w_old1     = r_line1[r_col];
    w_old2     = r_line2[r_col];
    w_col_last = (r_col == c_col_last);
    w_row_last = (r_row == c_row_last);
    w_win      = w_accept && (r_row != '0) && (r_col != '0);
    w_fl_step  = (state_q == FLUSH) && !r_eol_pend && !r_fl_done;
    // Centre column 0 mirrors its left neighbour onto the right one.
    w_dn_l     = (r_col == c_col_one) ? w_pix : r_cur_d2;
    // Centre row 0 mirrors the upper row onto the lower one.
    w_up_r     = (r_row == c_row_one) ? w_pix : w_old2;
    w_up_l     = (r_row == c_row_one) ? w_dn_l :
                 ((r_col == c_col_one) ? w_old2 : r_up_d2);
    // Last-row flush reads row ImgHeight-2, which serves as both up and down.
    w_fl_li    = (r_col == '0) ? c_col_one : (r_col - c_col_one);
    w_fl_ri    = w_col_last ? (c_col_last - c_col_one) : (r_col + c_col_one);
    w_fl_l     = r_line2[w_fl_li];
    w_fl_r     = r_line2[w_fl_ri];
  end

  // Output window selection: pending end-of-line first, then flush, then accept.
  always_comb begin
    w_ov   = 1'b0;
    w_osof = 1'b0;
    w_oeol = 1'b0;
    w_ul   = '0;
    w_ur   = '0;
    w_dl   = '0;
    w_dr   = '0;
    if (r_eol_pend) begin
      w_ov   = 1'b1;
      w_oeol = 1'b1;
      w_ul   = r_eol_up;
      w_ur   = r_eol_up;
      w_dl   = r_eol_dn;
      w_dr   = r_eol_dn;
    end else if (w_fl_step) begin
      w_ov   = 1'b1;
      w_oeol = w_col_last;
      w_ul   = w_fl_l;
      w_ur   = w_fl_r;
      w_dl   = w_fl_l;
      w_dr   = w_fl_r;
    end else if (w_win) begin
      w_ov   = 1'b1;
      w_osof = (r_row == c_row_one) && (r_col == c_col_one);
      w_ul   = w_up_l;
      w_ur   = w_up_r;
      w_dl   = w_dn_l;
      w_dr   = w_pix;
    end
  end

`ifdef CFA_WIN_COORD_EN
  // Centre coordinates matching the selected window.
  always_comb begin
    w_orow = '0;
    w_ocol = '0;
    if (r_eol_pend) begin
      w_orow = r_eol_row;
      w_ocol = c_col_last;
    end else if (w_fl_step) begin
      w_orow = c_row_last;
      w_ocol = r_col;
    end else if (w_win) begin
      w_orow = r_row - c_row_one;
      w_ocol = r_col - c_col_one;
    end
  end
`endif

  // Frame-phase next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept) state_d = FILL;
      FILL:    if (w_accept && (r_row == c_row_one) && (r_col == c_col_one)) state_d = RUN;
      RUN:     if (w_accept && w_row_last && w_col_last) state_d = FLUSH;
      FLUSH:   if (r_fl_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Line buffer shift on accept; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line2[r_col] <= w_old1;
      r_line1[r_col] <= w_pix;
    end
  end

  // Raster counters, horizontal delays, end-of-line capture and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_ready    <= 1'b0;
      r_eol_pend <= 1'b0;
      r_fl_done  <= 1'b0;
      r_cur_d1   <= '0;
      r_cur_d2   <= '0;
      r_up_d1    <= '0;
      r_up_d2    <= '0;
      r_eol_up   <= '0;
      r_eol_dn   <= '0;
    end else begin
      r_ready    <= (state_d != FLUSH);
      r_eol_pend <= w_accept && w_col_last && (r_row != '0);
      r_fl_done  <= w_fl_step && w_col_last;
      if (w_accept) begin
        r_col    <= w_col_last ? '0 : (r_col + c_col_one);
        if (w_col_last) r_row <= w_row_last ? '0 : (r_row + c_row_one);
        r_cur_d2 <= r_cur_d1;
        r_cur_d1 <= w_pix;
        r_up_d2  <= r_up_d1;
        r_up_d1  <= w_old2;
        if (w_col_last) begin
          r_eol_up <= (r_row == c_row_one) ? r_cur_d1 : r_up_d1;
          r_eol_dn <= r_cur_d1;
        end
      end else if (w_fl_step) begin
        r_col <= w_col_last ? '0 : (r_col + c_col_one);
      end
    end
  end

`ifdef CFA_WIN_COORD_EN
  // Row of the pending end-of-line window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_eol_row <= '0;
    else if (w_accept && w_col_last) r_eol_row <= r_row - c_row_one;
  end
`endif

  // Registered outputs; taps hold when no window is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      {G_m1_m1, RB_m1_m1} <= '0;
      {G_m1_p1, RB_m1_p1} <= '0;
      {G_p1_m1, RB_p1_m1} <= '0;
      {G_p1_p1, RB_p1_p1} <= '0;
`ifdef CFA_WIN_COORD_EN
      out_row <= '0;
      out_col <= '0;
`endif
    end else begin
      out_valid <= w_ov;
      out_sof   <= w_osof;
      out_eol   <= w_oeol;
      if (w_ov) begin
        {G_m1_m1, RB_m1_m1} <= w_ul;
        {G_m1_p1, RB_m1_p1} <= w_ur;
        {G_p1_m1, RB_p1_m1} <= w_dl;
        {G_p1_p1, RB_p1_p1} <= w_dr;
`ifdef CFA_WIN_COORD_EN
        out_row <= w_orow;
        out_col <= w_ocol;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfa_diag_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfa_diag_window_gen
// Description : Self-checking bench for cfa_diag_window_gen (6x4 frame,
//               12-bit samples). Expected windows come from a mirrored-border
//               array model of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfa_diag_window_gen;

  localparam int W  = 6;
  localparam int H  = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] G_in = '0;
  logic [DW-1:0] RB_in = '0;
  logic          out_valid, out_sof, out_eol;
  logic [DW-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
  logic [DW-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
`ifdef CFA_WIN_COORD_EN
  logic [1:0]    out_row;
  logic [2:0]    out_col;
`endif

  cfa_diag_window_gen #(.DataBitWidth(DW), .ImgWidth(W), .ImgHeight(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .G_in(G_in), .RB_in(RB_in),
    .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
    .G_m1_m1(G_m1_m1), .G_m1_p1(G_m1_p1), .G_p1_m1(G_p1_m1), .G_p1_p1(G_p1_p1),
    .RB_m1_m1(RB_m1_m1), .RB_m1_p1(RB_m1_p1), .RB_p1_m1(RB_p1_m1), .RB_p1_p1(RB_p1_p1)
`ifdef CFA_WIN_COORD_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [97:0] w;
    int          r;
    int          c;
    logic        rdy;
  } win_t;

  win_t          obs_q[$];
  win_t          exp_q[$];
  logic [DW-1:0] gp [H][W];
  logic [DW-1:0] rp [H][W];
  int            pass_cnt = 0;
  int            tot_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Collect every emitted window together with in_ready at that cycle.
  always @(negedge clk) begin
    win_t o;
    if (out_valid === 1'b1) begin
      o.w   = {G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
               RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1, out_sof, out_eol};
      o.rdy = in_ready;
`ifdef CFA_WIN_COORD_EN
      o.r = int'(out_row);
      o.c = int'(out_col);
`else
      o.r = -1;
      o.c = -1;
`endif
      obs_q.push_back(o);
    end
  end

  function automatic int mir(input int i, input int n);
    if (i < 0)  return 1;
    if (i >= n) return n - 2;
    return i;
  endfunction

  function automatic logic [2*DW-1:0] px(input int r, input int c);
    int rr, cc;
    rr = mir(r, H);
    cc = mir(c, W);
    return {gp[rr][cc], rp[rr][cc]};
  endfunction

  // kind 0: G=16r+c, RB=0x800+16r+c; 1: random; 2: G=0x100+16r+c, RB=0x900+16r+c
  task automatic prep(input int kind, input bit push);
    logic [2*DW-1:0] ul, ur, dl, dr;
    win_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       begin gp[r][c] = 12'(16*r + c);         rp[r][c] = 12'(12'h800 + 16*r + c); end
          1:       begin gp[r][c] = 12'($urandom);         rp[r][c] = 12'($urandom);           end
          default: begin gp[r][c] = 12'(12'h100 + 16*r + c); rp[r][c] = 12'(12'h900 + 16*r + c); end
        endcase
      end
    if (push)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          ul = px(r-1, c-1); ur = px(r-1, c+1);
          dl = px(r+1, c-1); dr = px(r+1, c+1);
          e.w   = {ul[23:12], ur[23:12], dl[23:12], dr[23:12],
                   ul[11:0], ur[11:0], dl[11:0], dr[11:0],
                   (r == 0 && c == 0), (c == W-1)};
          e.r   = r;
          e.c   = c;
          e.rdy = 1'b0;
          exp_q.push_back(e);
        end
  endtask

  // mode 0: valid always; 1: valid every other cycle; 2: random valid
  task automatic send_frame(input int mode, input int npix);
    int r = 0, c = 0, n = 0, cyc = 0;
    logic v;
    while (n < npix && cyc < 1000) begin
      @(negedge clk);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = ((cyc % 2) == 0);
      else                v = 1'($urandom_range(0, 1));
      in_valid = v;
      G_in     = gp[r][c];
      RB_in    = rp[r][c];
      cyc++;
      if (v && in_ready) begin
        n++;
        c++;
        if (c == W) begin c = 0; r++; if (r == H) r = 0; end
      end
    end
    if (n < npix) begin
      tot_cnt++;
      $error("FAIL send_timeout: accepted %0d required %0d", n, npix);
    end
  endtask

  task automatic stop_input();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // directed 1: pattern-0 frame constants; 2: pattern-2 frame constants
  task automatic check_windows(input string tag, input int nframes, input int directed,
                               input bit ready_after);
    win_t e, o;
    int sofs = 0, eols = 0, guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (obs_q.size() == 0 && guard < 300) begin @(negedge clk); guard++; end
      if (obs_q.size() == 0) begin
        tot_cnt++;
        $error("FAIL %s_timeout: observed 0 windows, expected %0d more", tag, exp_q.size());
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_win(%0d,%0d)", tag, e.r, e.c), 128'(o.w), 128'(e.w));
      if (e.r == H-1)
        chk($sformatf("%s_flush_ready(%0d,%0d)", tag, e.r, e.c), 128'(o.rdy), 128'(0));
`ifdef CFA_WIN_COORD_EN
      chk($sformatf("%s_row(%0d,%0d)", tag, e.r, e.c), 128'(o.r), 128'(e.r));
      chk($sformatf("%s_col(%0d,%0d)", tag, e.r, e.c), 128'(o.c), 128'(e.c));
`endif
      if (directed == 1 && e.r == 1 && e.c == 2) begin
        chk("centre12_G", 128'(o.w[97:50]), 128'({12'h001, 12'h003, 12'h021, 12'h023}));
        chk("centre12_RB", 128'(o.w[49:2]), 128'({12'h801, 12'h803, 12'h821, 12'h823}));
      end
      if (directed == 1 && e.r == 0 && e.c == 0)
        chk("corner00_G", 128'(o.w[97:50]), 128'({4{12'h011}}));
      if (directed == 1 && e.r == 3 && e.c == 5)
        chk("corner35_G", 128'(o.w[97:50]), 128'({4{12'h024}}));
      if (directed == 2 && e.r == 0 && e.c == 0)
        chk("rst_corner00_G", 128'(o.w[97:50]), 128'({4{12'h111}}));
      sofs += int'(o.w[1]);
      eols += int'(o.w[0]);
    end
    chk($sformatf("%s_sof_count", tag), 128'(sofs), 128'(nframes));
    chk($sformatf("%s_eol_count", tag), 128'(eols), 128'(nframes * H));
    if (ready_after) begin
      @(negedge clk);
      chk($sformatf("%s_ready_after_flush", tag), 128'(in_ready), 128'(1));
    end
    repeat (4) @(negedge clk);
    chk($sformatf("%s_extra_windows", tag), 128'(obs_q.size()), 128'(0));
    obs_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sof_eol", 128'({out_sof, out_eol}), 128'(0));
    chk("rst_taps", 128'({G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
                          RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1}), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("release_in_ready_low", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("release_in_ready_high", 128'(in_ready), 128'(1));

    // Continuous full frame, directed pattern
    prep(0, 1'b1);
    send_frame(0, W*H);
    stop_input();
    check_windows("cont", 1, 1, 1'b1);

    // in_valid toggling every cycle, same pattern
    prep(0, 1'b1);
    send_frame(1, W*H);
    stop_input();
    check_windows("toggle", 1, 1, 1'b1);

    // Random data with random in_valid
    prep(1, 1'b1);
    send_frame(2, W*H);
    stop_input();
    check_windows("rand", 1, 0, 1'b1);

    // Two random frames back to back
    prep(1, 1'b1);
    send_frame(0, W*H);
    prep(1, 1'b1);
    send_frame(0, W*H);
    stop_input();
    check_windows("b2b", 2, 0, 1'b1);

    // Reset in the middle of row 2
    prep(0, 1'b0);
    send_frame(0, 2*W + 3);
    stop_input();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_taps", 128'({G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
                             RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1}), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    @(negedge clk);
    chk("midrst_release_ready", 128'(in_ready), 128'(1));
    prep(2, 1'b1);
    send_frame(0, W*H);
    stop_input();
    check_windows("after_rst", 1, 2, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
